alu_insn_encoder: RTL and testbench
===================================

// Module: alu_insn_encoder
// PURPOSE
//  Inverse of the ALU decoder. Takes an ALU-operation request and emits one or more
//  legal MIPS instruction words whose decode reproduces that ALUop.
//  The codebase uses it in the self-test instruction generator and boot-time IMEM loader.
//  A 32-bit immediate that fits no I-type form expands into LUI/ORI into AT_REG, then an R-type.
//  Valid/ready on both sides; a request's words leave in order, and the last is flagged.
// PARAMETERS
//  AT_REG  5'd1  scratch register ($at) used for immediate expansion
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   request accepted when req_valid && req_ready
//  req_aluop  in   4   ALU op, encoding per the shared ALUop.vh
//  req_rd     in   5   destination register
//  req_rs     in   5   source A (value to shift for shift ops)
//  req_rt     in   5   source B register (shift amount for variable shifts)
//  req_useimm in   1   1: operand B is req_imm, not req_rt
//  req_imm    in   32  immediate operand B
//  out_valid  out  1   out_insn valid
//  out_ready  in   1   consumer accepts when out_valid && out_ready
//  out_insn   out  32  encoded instruction word
//  out_last   out  1   word is the final one of its request
//  req_err    out  1   one-cycle pulse: accepted request unencodable, dropped, no words emitted
// BEHAVIOUR
//  Reset: state IDLE; out_valid=0, out_insn=0, out_last=0, req_err=0; req_ready=1 after reset.
//  FSM states: IDLE, EMIT_LUI, EMIT_ORI, EMIT_OP.
//   - IDLE: accept a request; encode it next cycle.
//   - EMIT_LUI -> EMIT_ORI when imm[15:0]!=0, otherwise -> EMIT_OP.
//   - EMIT_ORI -> EMIT_OP.
//   - EMIT_OP -> IDLE, or back-to-back into the next request.
//  Advance only on out_valid && out_ready. out_insn and out_last stay stable while stalled.
//  req_ready = IDLE, or (out_last && out_valid && out_ready): zero-bubble back-to-back issue.
//  Latency: single-word request accepted at cycle N gives out_valid at N+1.
//  Register form (useimm=0):
//   - ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU -> R-type rd,rs,rt with the matching funct.
//   - SLL/SRL/SRA -> SLLV/SRLV/SRAV rd, rt<-rs, rs<-rt.
//  Immediate form (useimm=1), single word when it fits:
//   - ADDU, SLT, SLTU -> ADDIU/SLTI/SLTIU rt=rd if imm is sign-extended 16-bit.
//   - SUBU -> ADDIU with -imm if -imm is sign-extended 16-bit.
//   - AND, OR, XOR -> ANDI/ORI/XORI if imm[31:16]==0.
//   - Shifts -> SLL/SRL/SRA rt=rs, shamt=imm[4:0]; error if imm>31.
//   - LUI -> LUI rt=rd, imm[15:0]; error if imm[31:16]!=0.
//  Expansion (immediate does not fit, or NOR with useimm):
//   - LUI AT,imm[31:16]; ORI AT,AT,imm[15:0] (skipped when zero); R-type rd,rs,AT.
//   - SUBU expansion loads imm itself and uses SUBU rd,rs,AT.
//  Errors, all with req_err pulse:
//   - expansion required and (rs==AT or rd==AT);
//   - shift amount >31;
//   - LUI with wide imm;
//   - unknown ALUop.
//  Reset mid-sequence: partial words abandoned, FSM to IDLE; consumer discards an unterminated run.
//  Output arithmetic is purely bitfield; -imm is 32-bit two's complement; fit checks use bits [31:15].
// STRUCTURE
//  Opcode/funct constants come from Opcode.vh; ALUop codes come from ALUop.vh (shared include).
//  Add to Opcode.vh: `MIPS_RTYPE_WORD / `MIPS_ITYPE_WORD field-packing macros.
//  One sub-module: alu_imm_classify (combinational).
//   - Outputs fits_simm16, fits_uimm16, fits_neg_simm16, lo_zero.
//   - Shared by encoding and FSM next-state.
// TESTING
//  ADDU rd=3 rs=1 rt=2 useimm=0 -> 0x00221821, last=1, one cycle after accept.
//  ADDU rd=2 rs=4 imm=0x10 -> ADDIU 0x24820010; SUBU rd=2 rs=4 imm=1 -> 0x2482FFFF.
//  OR rd=5 rs=6 imm=0x12345678 -> 0x3C011234, 0x34215678, 0x00C12825; last only on third.
//  SLL rd=2 rs=3 imm=4 -> 0x00031100; same with imm=40 -> req_err pulse, no out_valid.
//  Hold out_ready=0 for 5 cycles mid-expansion -> words stable; next request waits until last accepted.
//  Back-to-back single-word requests with out_ready=1 -> one word per cycle.
//  rst_n low mid-expansion -> out_valid=0 immediately; req_ready=1 after release.
//  OR rd=1 (AT) with wide imm -> req_err, no words.

Source files
------------

// File: rtl/alu_insn_encoder_pkg.sv
// Shared types, MIPS field constants and word-packing helpers for the ALU
// instruction encoder and its immediate classifier.
package alu_insn_encoder_pkg;

    // ALU operation codes as produced by the ALU decoder.
    typedef enum logic [3:0] {
        ALU_ADDU = 4'd0,
        ALU_SUBU = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } aluop_e;

    // Which word of the current request is being presented on the output.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EMIT_LUI = 2'd1,
        EMIT_ORI = 2'd2,
        EMIT_OP  = 2'd3
    } state_e;

    // Primary opcodes.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;

    // R-type function codes.
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2a;
    localparam logic [5:0] F_SLTU = 6'h2b;

    // Pack an R-type word: op | rs | rt | rd | shamt | funct.
    function automatic logic [31:0] rtype_word(input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [4:0] rd, input logic [4:0] shamt,
                                               input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    // Pack an I-type word: op | rs | rt | imm16.
    function automatic logic [31:0] itype_word(input logic [5:0] op, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Funct for the two-register arithmetic/logic ops; 0 for anything else.
    function automatic logic [5:0] rtype_funct(input aluop_e op);
        case (op)
            ALU_ADDU: return F_ADDU;
            ALU_SUBU: return F_SUBU;
            ALU_AND:  return F_AND;
            ALU_OR:   return F_OR;
            ALU_XOR:  return F_XOR;
            ALU_NOR:  return F_NOR;
            ALU_SLT:  return F_SLT;
            ALU_SLTU: return F_SLTU;
            default:  return 6'h00;
        endcase
    endfunction

    // Funct for a shift op, either the shamt form or the register-amount form.
    function automatic logic [5:0] shift_funct(input aluop_e op, input logic variable);
        case (op)
            ALU_SRL: return variable ? F_SRLV : F_SRL;
            ALU_SRA: return variable ? F_SRAV : F_SRA;
            default: return variable ? F_SLLV : F_SLL;
        endcase
    endfunction

    // Opcode of the single-word immediate form of an op; 0 when there is none.
    function automatic logic [5:0] itype_opcode(input aluop_e op);
        case (op)
            ALU_ADDU: return OP_ADDIU;
            ALU_SLT:  return OP_SLTI;
            ALU_SLTU: return OP_SLTIU;
            ALU_AND:  return OP_ANDI;
            ALU_OR:   return OP_ORI;
            ALU_XOR:  return OP_XORI;
            ALU_LUI:  return OP_LUI;
            default:  return 6'h00;
        endcase
    endfunction

endpackage

// File: rtl/alu_imm_classify.sv
// Combinational fit classification of a 32-bit immediate against the 16-bit
// I-type immediate forms. Fit tests look only at the bits above the field.
module alu_imm_classify
    import alu_insn_encoder_pkg::*;
(
    input  logic [31:0] imm,
    output logic        fits_simm16,
    output logic        fits_uimm16,
    output logic        fits_neg_simm16,
    output logic        lo_zero
);

    logic [31:0] neg_imm;

    assign neg_imm         = 32'd0 - imm;
    assign fits_simm16     = (imm[31:15] == 17'h00000) || (imm[31:15] == 17'h1ffff);
    assign fits_uimm16     = (imm[31:16] == 16'h0000);
    assign fits_neg_simm16 = (neg_imm[31:15] == 17'h00000) || (neg_imm[31:15] == 17'h1ffff);
    assign lo_zero         = (imm[15:0] == 16'h0000);

endmodule

// File: rtl/alu_insn_encoder.sv
// Turns an ALU-operation request into one to three MIPS instruction words.
// Immediates that fit no I-type form are built in AT_REG with LUI/ORI and the
// operation is then issued as an R-type against AT_REG. Output words are
// registered, held while stalled, and the final word of a request is flagged.
module alu_insn_encoder
    import alu_insn_encoder_pkg::*;
#(
    parameter logic [4:0] AT_REG = 5'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_aluop,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic        req_useimm,
    input  logic [31:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic        out_last,
    output logic        req_err
);

    state_e      state, state_nxt;
    aluop_e      op_in;
    aluop_e      aluop_q;
    logic [4:0]  rd_q, rs_q;
    logic [15:0] imm_lo_q;
    logic        lo_zero_q;

    logic        fits_simm16, fits_uimm16, fits_neg_simm16, lo_zero;
    logic [15:0] neg_lo;

    logic        acc_err, acc_single, need_exp;
    logic [31:0] acc_word;

    logic        fire_out, accept, take;
    logic        valid_nxt, last_nxt, err_nxt;
    logic [31:0] insn_nxt;
    logic [31:0] ori_word, op_word;

    assign op_in    = aluop_e'(req_aluop);
    assign neg_lo   = 16'd0 - req_imm[15:0];
    assign fire_out = out_valid && out_ready;
    // A new request can enter while idle or in the same cycle the final word leaves.
    assign req_ready = (state == IDLE) || (out_last && fire_out);
    assign accept    = req_valid && req_ready;

    assign ori_word = itype_word(OP_ORI, AT_REG, AT_REG, imm_lo_q);
    assign op_word  = rtype_word(rs_q, AT_REG, rd_q, 5'd0, rtype_funct(aluop_q));

    alu_imm_classify u_classify (
        .imm             (req_imm),
        .fits_simm16     (fits_simm16),
        .fits_uimm16     (fits_uimm16),
        .fits_neg_simm16 (fits_neg_simm16),
        .lo_zero         (lo_zero)
    );

    // Encode the incoming request: error, single word, or first word of an expansion.
    // LUI has no register-operand form, so LUI without useimm is treated as unencodable.
    always_comb begin
        acc_err    = 1'b0;
        acc_single = 1'b0;
        need_exp   = 1'b0;
        acc_word   = 32'd0;
        if (!req_useimm) begin
            case (op_in)
                ALU_ADDU, ALU_SUBU, ALU_AND, ALU_OR,
                ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU: begin
                    acc_single = 1'b1;
                    acc_word   = rtype_word(req_rs, req_rt, req_rd, 5'd0, rtype_funct(op_in));
                end
                ALU_SLL, ALU_SRL, ALU_SRA: begin
                    // Variable shifts take the amount in rs and the value in rt.
                    acc_single = 1'b1;
                    acc_word   = rtype_word(req_rt, req_rs, req_rd, 5'd0, shift_funct(op_in, 1'b1));
                end
                default: acc_err = 1'b1;
            endcase
        end else begin
            case (op_in)
                ALU_ADDU, ALU_SLT, ALU_SLTU: begin
                    if (fits_simm16) begin
                        acc_single = 1'b1;
                        acc_word   = itype_word(itype_opcode(op_in), req_rs, req_rd, req_imm[15:0]);
                    end else begin
                        need_exp = 1'b1;
                    end
                end
                ALU_SUBU: begin
                    if (fits_neg_simm16) begin
                        acc_single = 1'b1;
                        acc_word   = itype_word(OP_ADDIU, req_rs, req_rd, neg_lo);
                    end else begin
                        need_exp = 1'b1;
                    end
                end
                ALU_AND, ALU_OR, ALU_XOR: begin
                    if (fits_uimm16) begin
                        acc_single = 1'b1;
                        acc_word   = itype_word(itype_opcode(op_in), req_rs, req_rd, req_imm[15:0]);
                    end else begin
                        need_exp = 1'b1;
                    end
                end
                ALU_NOR: need_exp = 1'b1;
                ALU_SLL, ALU_SRL, ALU_SRA: begin
                    if (req_imm[31:5] != 27'd0) begin
                        acc_err = 1'b1;
                    end else begin
                        acc_single = 1'b1;
                        acc_word   = rtype_word(5'd0, req_rs, req_rd, req_imm[4:0],
                                                shift_funct(op_in, 1'b0));
                    end
                end
                ALU_LUI: begin
                    if (!fits_uimm16) begin
                        acc_err = 1'b1;
                    end else begin
                        acc_single = 1'b1;
                        acc_word   = itype_word(OP_LUI, 5'd0, req_rd, req_imm[15:0]);
                    end
                end
                default: acc_err = 1'b1;
            endcase
            // Expansion clobbers AT_REG, so it cannot also be a source or destination.
            if (need_exp) begin
                if ((req_rs == AT_REG) || (req_rd == AT_REG)) begin
                    acc_err = 1'b1;
                end else begin
                    acc_word = itype_word(OP_LUI, 5'd0, AT_REG, req_imm[31:16]);
                end
            end
        end
    end

    // Next state and next output word; everything advances only when the current word is taken.
    always_comb begin
        state_nxt = state;
        valid_nxt = out_valid;
        insn_nxt  = out_insn;
        last_nxt  = out_last;
        err_nxt   = 1'b0;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) take = 1'b1;
            end
            EMIT_LUI: begin
                if (fire_out) begin
                    if (lo_zero_q) begin
                        state_nxt = EMIT_OP;
                        insn_nxt  = op_word;
                        last_nxt  = 1'b1;
                    end else begin
                        state_nxt = EMIT_ORI;
                        insn_nxt  = ori_word;
                    end
                end
            end
            EMIT_ORI: begin
                if (fire_out) begin
                    state_nxt = EMIT_OP;
                    insn_nxt  = op_word;
                    last_nxt  = 1'b1;
                end
            end
            EMIT_OP: begin
                if (fire_out) begin
                    if (accept) begin
                        take = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (take) begin
            if (acc_err) begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
                err_nxt   = 1'b1;
            end else if (acc_single) begin
                state_nxt = EMIT_OP;
                valid_nxt = 1'b1;
                insn_nxt  = acc_word;
                last_nxt  = 1'b1;
            end else begin
                state_nxt = EMIT_LUI;
                valid_nxt = 1'b1;
                insn_nxt  = acc_word;
                last_nxt  = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Output word register; reset abandons any partially emitted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_insn  <= 32'd0;
            out_last  <= 1'b0;
            req_err   <= 1'b0;
        end else begin
            out_valid <= valid_nxt;
            out_insn  <= insn_nxt;
            out_last  <= last_nxt;
            req_err   <= err_nxt;
        end
    end

    // Capture the fields the later expansion words need when a request is taken.
    always_ff @(posedge clk) begin
        if (take) begin
            aluop_q   <= op_in;
            rd_q      <= req_rd;
            rs_q      <= req_rs;
            imm_lo_q  <= req_imm[15:0];
            lo_zero_q <= lo_zero;
        end
    end

endmodule

// File: tb/tb_alu_insn_encoder.sv
// Bench for alu_insn_encoder: directed requests, a behavioural encoding model
// feeding an expected-word queue, and a per-cycle compare of every output.
module tb_alu_insn_encoder;
    import alu_insn_encoder_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_aluop;
    logic [4:0]  req_rd, req_rs, req_rt;
    logic        req_useimm;
    logic [31:0] req_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic        out_last;
    logic        req_err;

    int          checks;
    int          errors;
    logic [32:0] exp_q[$];
    bit          err_exp;
    bit          m_rdy, m_acc, m_err;
    int          m_n;
    logic [31:0] m_w0, m_w1, m_w2;

    alu_insn_encoder #(.AT_REG(5'd1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_aluop  (req_aluop),
        .req_rd     (req_rd),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .req_useimm (req_useimm),
        .req_imm    (req_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_insn   (out_insn),
        .out_last   (out_last),
        .req_err    (req_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] rw(input int rs, input int rt, input int rd, input int sh, input int fn);
        return 32'(rs) * 32'h200000 + 32'(rt) * 32'h10000 + 32'(rd) * 32'h800 + 32'(sh) * 32'h40 + 32'(fn);
    endfunction

    function automatic logic [31:0] iw(input int op, input int rs, input int rt, input logic [31:0] imm);
        return 32'(op) * 32'h4000000 + 32'(rs) * 32'h200000 + 32'(rt) * 32'h10000 + (imm % 32'h10000);
    endfunction

    function automatic int rfunct(input logic [3:0] op);
        case (op)
            ALU_ADDU: return 'h21;
            ALU_SUBU: return 'h23;
            ALU_AND:  return 'h24;
            ALU_OR:   return 'h25;
            ALU_XOR:  return 'h26;
            ALU_NOR:  return 'h27;
            ALU_SLT:  return 'h2a;
            default:  return 'h2b;
        endcase
    endfunction

    // Encoding rules in plain arithmetic: returns the word list (n words) or err.
    task automatic model(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic ui, input logic [31:0] imm,
                         output bit err, output int n,
                         output logic [31:0] w0, output logic [31:0] w1, output logic [31:0] w2);
        longint      s, sn;
        logic [31:0] neg;
        bit          expand;
        s = longint'($signed(imm));
        neg = 32'd0 - imm;
        sn = longint'($signed(neg));
        err = 0; n = 0; w0 = 0; w1 = 0; w2 = 0; expand = 0;
        if (op > 11) begin
            err = 1;
        end else if (!ui) begin
            if (op <= 7) begin n = 1; w0 = rw(rs, rt, rd, 0, rfunct(op)); end
            else if (op <= 10) begin n = 1; w0 = rw(rt, rs, rd, 0, (op == 8) ? 4 : (op == 9) ? 6 : 7); end
            else err = 1;
        end else begin
            case (op)
                ALU_ADDU, ALU_SLT, ALU_SLTU:
                    if (s >= -32768 && s <= 32767) begin
                        n = 1; w0 = iw((op == ALU_ADDU) ? 9 : (op == ALU_SLT) ? 10 : 11, rs, rd, imm);
                    end else expand = 1;
                ALU_SUBU:
                    if (sn >= -32768 && sn <= 32767) begin n = 1; w0 = iw(9, rs, rd, neg); end
                    else expand = 1;
                ALU_AND, ALU_OR, ALU_XOR:
                    if (imm <= 32'd65535) begin
                        n = 1; w0 = iw((op == ALU_AND) ? 12 : (op == ALU_OR) ? 13 : 14, rs, rd, imm);
                    end else expand = 1;
                ALU_NOR: expand = 1;
                ALU_SLL, ALU_SRL, ALU_SRA:
                    if (imm > 32'd31) err = 1;
                    else begin n = 1; w0 = rw(0, rs, rd, int'(imm), (op == 8) ? 0 : (op == 9) ? 2 : 3); end
                default:
                    if (imm > 32'd65535) err = 1;
                    else begin n = 1; w0 = iw(15, 0, rd, imm); end
            endcase
        end
        if (expand) begin
            if (rs == 5'd1 || rd == 5'd1) begin
                err = 1;
            end else begin
                w0 = iw(15, 0, 1, imm / 32'h10000);
                if (imm % 32'h10000 != 0) begin
                    n = 3; w1 = iw(13, 1, 1, imm); w2 = rw(rs, 1, rd, 0, rfunct(op));
                end else begin
                    n = 2; w1 = rw(rs, 1, rd, 0, rfunct(op));
                end
            end
        end
    endtask

    // Check the model itself against hand-computed words.
    task automatic pin(input string name, input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic ui, input logic [31:0] imm, input bit e_err,
                       input int e_n, input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        bit          err;
        int          n;
        logic [31:0] w0, w1, w2;
        model(op, rd, rs, rt, ui, imm, err, n, w0, w1, w2);
        chk({name, ".err"}, 32'(err), 32'(e_err));
        chk({name, ".n"}, 32'(n), 32'(e_n));
        if (e_n > 0) chk({name, ".w0"}, w0, e0);
        if (e_n > 1) chk({name, ".w1"}, w1, e1);
        if (e_n > 2) chk({name, ".w2"}, w2, e2);
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic ui, input logic [31:0] imm);
        req_valid = 1'b1; req_aluop = op; req_rd = rd; req_rs = rs;
        req_rt = rt; req_useimm = ui; req_imm = imm;
    endtask

    task automatic wait_accept();
        bit got;
        got = 0;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                got = 1;
            end
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        #1 req_valid = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs,
                        input logic [4:0] rt, input logic ui, input logic [31:0] imm);
        drive(op, rd, rs, rt, ui, imm);
        wait_accept();
    endtask

    initial begin
        checks = 0; errors = 0; err_exp = 0;
        rst_n = 1'b1; req_valid = 1'b0; out_ready = 1'b1;
        req_aluop = 4'd0; req_rd = 5'd0; req_rs = 5'd0; req_rt = 5'd0;
        req_useimm = 1'b0; req_imm = 32'd0;
        fork
            // Stimulus.
            begin
                #1 rst_n = 1'b0;
                repeat (3) @(posedge clk);
                #2 rst_n = 1'b1;

                pin("p_addu_r", ALU_ADDU, 5'd3, 5'd1, 5'd2, 1'b0, 32'd0, 0, 1, 32'h00221821, 0, 0);
                pin("p_addiu", ALU_ADDU, 5'd2, 5'd4, 5'd0, 1'b1, 32'h10, 0, 1, 32'h24820010, 0, 0);
                pin("p_subu_i", ALU_SUBU, 5'd2, 5'd4, 5'd0, 1'b1, 32'd1, 0, 1, 32'h2482FFFF, 0, 0);
                pin("p_or_exp", ALU_OR, 5'd5, 5'd6, 5'd0, 1'b1, 32'h12345678, 0, 3,
                    32'h3C011234, 32'h34215678, 32'h00C12825);
                pin("p_sll", ALU_SLL, 5'd2, 5'd3, 5'd0, 1'b1, 32'd4, 0, 1, 32'h00031100, 0, 0);
                pin("p_sll40", ALU_SLL, 5'd2, 5'd3, 5'd0, 1'b1, 32'd40, 1, 0, 0, 0, 0);
                pin("p_or_at", ALU_OR, 5'd1, 5'd6, 5'd0, 1'b1, 32'h12345678, 1, 0, 0, 0, 0);

                // Single-word latency from idle.
                out_ready = 1'b1;
                send(ALU_ADDU, 5'd3, 5'd1, 5'd2, 1'b0, 32'd0);
                @(negedge clk);
                chk("addu_lat_valid", 32'(out_valid), 32'd1);
                chk("addu_lat_insn", out_insn, 32'h00221821);
                chk("addu_lat_last", 32'(out_last), 32'd1);
                @(posedge clk); #1;

                // Back-to-back mix of single words, expansions and errors.
                send(ALU_ADDU, 5'd2, 5'd4, 5'd0, 1'b1, 32'h10);
                send(ALU_SUBU, 5'd2, 5'd4, 5'd0, 1'b1, 32'd1);
                send(ALU_AND, 5'd7, 5'd8, 5'd9, 1'b0, 32'd0);
                send(ALU_XOR, 5'd10, 5'd11, 5'd0, 1'b1, 32'hFF);
                send(ALU_SLTU, 5'd12, 5'd13, 5'd0, 1'b1, 32'hFFFF8000);
                send(ALU_SRA, 5'd14, 5'd15, 5'd16, 1'b0, 32'd0);
                send(ALU_SRL, 5'd17, 5'd18, 5'd0, 1'b1, 32'd31);
                send(ALU_LUI, 5'd19, 5'd0, 5'd0, 1'b1, 32'hABCD);
                send(ALU_SLT, 5'd20, 5'd21, 5'd0, 1'b1, 32'hFFFFFFFF);
                send(ALU_SUBU, 5'd22, 5'd23, 5'd0, 1'b1, 32'h8000);
                send(ALU_OR, 5'd5, 5'd6, 5'd0, 1'b1, 32'h12345678);
                send(ALU_SLL, 5'd2, 5'd3, 5'd0, 1'b1, 32'd4);
                send(ALU_SLL, 5'd2, 5'd3, 5'd0, 1'b1, 32'd40);
                send(ALU_ADDU, 5'd4, 5'd5, 5'd0, 1'b1, 32'h00018000);
                send(ALU_SUBU, 5'd6, 5'd7, 5'd0, 1'b1, 32'h12340000);
                send(ALU_NOR, 5'd8, 5'd9, 5'd0, 1'b1, 32'd0);
                send(ALU_XOR, 5'd10, 5'd11, 5'd0, 1'b1, 32'h10000);
                send(ALU_OR, 5'd1, 5'd6, 5'd0, 1'b1, 32'h12345678);
                send(ALU_LUI, 5'd3, 5'd0, 5'd0, 1'b1, 32'h10000);
                send(4'd13, 5'd3, 5'd4, 5'd5, 1'b0, 32'd0);
                send(ALU_LUI, 5'd3, 5'd4, 5'd5, 1'b0, 32'd0);
                send(ALU_SUBU, 5'd3, 5'd1, 5'd0, 1'b1, 32'h80000000);
                send(ALU_SLTU, 5'd24, 5'd25, 5'd26, 1'b0, 32'd0);

                // Stall mid-expansion with the next request waiting.
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                send(ALU_OR, 5'd5, 5'd6, 5'd0, 1'b1, 32'h12345678);
                drive(ALU_ADDU, 5'd3, 5'd1, 5'd2, 1'b0, 32'd0);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall_insn", out_insn, 32'h3C011234);
                    chk("stall_req_ready", 32'(req_ready), 32'd0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
                wait_accept();

                // Partial stalls on the last word of an expansion.
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                send(ALU_NOR, 5'd8, 5'd9, 5'd0, 1'b1, 32'hFFFF0000);
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
                @(posedge clk); #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
                repeat (4) @(posedge clk);

                // Asynchronous reset mid-expansion.
                #1 out_ready = 1'b0;
                send(ALU_OR, 5'd5, 5'd6, 5'd0, 1'b1, 32'h12345678);
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1 chk("rst_async_valid", 32'(out_valid), 32'd0);
                chk("rst_async_insn", out_insn, 32'd0);
                repeat (2) @(posedge clk);
                #2 rst_n = 1'b1;
                out_ready = 1'b1;
                @(negedge clk);
                chk("rst_release_ready", 32'(req_ready), 32'd1);
                @(posedge clk); #1;
                send(ALU_ADDU, 5'd3, 5'd1, 5'd2, 1'b0, 32'd0);
                repeat (10) @(posedge clk);
            end
            // Expected-word queue: retire taken words, enqueue model words on accept.
            begin
                #2;
                forever begin
                    @(posedge clk);
                    if (!rst_n) begin
                        exp_q.delete();
                        err_exp = 0;
                    end else begin
                        m_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
                        m_acc = req_valid && m_rdy;
                        err_exp = 0;
                        if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
                        if (m_acc) begin
                            model(req_aluop, req_rd, req_rs, req_rt, req_useimm, req_imm,
                                  m_err, m_n, m_w0, m_w1, m_w2);
                            if (m_err) err_exp = 1;
                            if (m_n > 0) exp_q.push_back({(m_n == 1), m_w0});
                            if (m_n > 1) exp_q.push_back({(m_n == 2), m_w1});
                            if (m_n > 2) exp_q.push_back({1'b1, m_w2});
                        end
                    end
                end
            end
            // Per-cycle compare on the falling edge.
            begin
                #2;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        chk("reset_out_valid", 32'(out_valid), 32'd0);
                        chk("reset_out_insn", out_insn, 32'd0);
                        chk("reset_out_last", 32'(out_last), 32'd0);
                        chk("reset_req_err", 32'(req_err), 32'd0);
                        chk("reset_req_ready", 32'(req_ready), 32'd1);
                    end else begin
                        chk("out_valid", 32'(out_valid), (exp_q.size() > 0) ? 32'd1 : 32'd0);
                        chk("req_ready", 32'(req_ready),
                            ((exp_q.size() == 0) || (exp_q.size() == 1 && out_ready)) ? 32'd1 : 32'd0);
                        chk("req_err", 32'(req_err), 32'(err_exp));
                        if (exp_q.size() > 0) begin
                            chk("out_insn", out_insn, exp_q[0][31:0]);
                            chk("out_last", 32'(out_last), 32'(exp_q[0][32]));
                        end
                    end
                end
            end
            // Global time bound.
            begin
                #500000;
                chk("sim_timeout", 32'd0, 32'd1);
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
